control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle control and execute stage for the 8-bit mini CPU. It sits directly upstream of the 8x8 register file. It accepts 16-bit instructions from instruction memory over a valid/ready handshake, drives the register file read addresses, and executes through an internal ALU. It produces the register file write port (`write_enable`, `write_reg`, `write_data`) and owns the program counter.

## Interface
- `PC_W`, default 8: program counter width; jump/branch targets are `instr[7:0]`, zero-extended.
- `RESET_PC`, default 0: PC value after reset.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `instr_valid`  in  1  instruction word on `instr` is valid.
- `instr`  in  16  instruction: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm8.
- `instr_ready`  out  1  high only in FETCH.
- `pc`  out  PC_W  address of the instruction being fetched/executed.
- `read_reg1`, `read_reg2`  out  3  register file read addresses (rs1, rs2 of the captured instruction).
- `read_data1`, `read_data2`  in  8  register file combinational read data.
- `write_enable`  out  1  register file write strobe.
- `write_reg`  out  3  destination register.
- `write_data`  out  8  writeback value.
- `halted`  out  1  HALT executed; sticky until reset.
- `illegal`  out  1  undefined opcode seen; sticky until reset.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd <= rs1 op rs2, modulo 256 with no carry kept.
  - 6 LDI: rd <= imm8.
  - 7 MOV: rd <= rs1.
  - 8 JMP: pc <= imm8.
  - 9 BZ: if rs1 == 0, pc <= imm8, else pc+1.
  - 15 HALT.
  - 10–14: executed as NOP and set `illegal`.
- FSM states and transitions:
  - FETCH: `instr_ready`=1. On `instr_valid`, capture `instr` into the instruction register and go to DECODE. Otherwise stay.
  - DECODE: `read_reg1`/`read_reg2` come from the captured rs1/rs2. Latch `read_data1`/`read_data2` into operand registers, then go to EXECUTE.
  - EXECUTE: the ALU computes the result into the result register and evaluates the BZ condition. Go to WRITEBACK, or to HALT if the opcode is HALT.
  - WRITEBACK: `write_enable`=1 for one cycle, for ADD..MOV only. Update pc (jump target or pc+1, wrapping modulo 2^PC_W), then go to FETCH.
  - HALT: `instr_ready`=0, `halted`=1, pc frozen. Leaves only on reset.
- `write_enable`, `write_reg` and `write_data` decode from registered state only; there is no combinational path from `instr` or `read_data*`.
- `read_reg1`/`read_reg2` hold their value from DECODE until the next capture.
- Reset values, applied immediately on `rst_n` low: state FETCH, pc=`RESET_PC`, instruction register 0, `write_enable`=0, `write_reg`=0, `write_data`=0, `halted`=0, `illegal`=0.
- Reset mid-instruction discards the instruction. No partial write occurs, because `write_enable` drops asynchronously.

## Timing
- Handshake accepted at edge T (FETCH, `instr_valid`=1).
  - DECODE in cycle T+1, EXECUTE in T+2, WRITEBACK in T+3.
  - The register file is written at the edge ending T+3.
  - FETCH again in T+4.
- Fixed 4 cycles per instruction plus any FETCH wait cycles.
- pc changes at the edge leaving WRITEBACK. `pc` is stable through FETCH..WRITEBACK of one instruction.
- Back-to-back RAW dependences need no forwarding: the write completes before the next DECODE.
- `instr_valid` held high outside FETCH is ignored. `instr` need only be stable at the accepting edge.

## Structure
- Shared package `cpu_pkg` contains:
  - opcode localparams;
  - FSM state encoding;
  - instruction field bit positions;
  - the ALU op enumeration.
- One sub-module, `alu8`: purely combinational, with inputs op, a[7:0], b[7:0] and output y[7:0]. It implements ADD/SUB/AND/OR/XOR/PASS_A/PASS_B.

## Test plan
- Reset, then LDI r1,0x05: `write_enable` is high exactly in cycle T+3 with `write_reg`=1, `write_data`=0x05; pc goes 0→1.
- LDI r1,0xF0; LDI r2,0x20; ADD r3,r1,r2: r3 is written with 0x10 (wrap), with no stall between instructions beyond 4 cycles each.
- SUB r4,r1,r1 then BZ r4,0x40: BZ is taken, pc=0x40. Repeat with r4≠0: pc is the old pc+1.
- Opcode 0xC at pc 3: `illegal` goes to 1, there is no write, pc goes to 4, and `illegal` stays 1 on following instructions.
- HALT: `halted`=1 and `instr_ready`=0 indefinitely with `instr_valid` held high; pc is frozen. Assert `rst_n` low: all outputs return to reset values asynchronously.
- Assert `rst_n` low during the WRITEBACK of an ADD: `write_enable` falls before the clock edge and the destination register is unchanged. After release, the bench's `instr_valid` gaps of 0–3 cycles are honoured in FETCH.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit mini CPU: opcodes, instruction fields,
// control FSM states and ALU operations.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction field bit positions (imm8 overlaps rs1/rs2 by design).
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_MSB = 8;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_MSB = 5;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_PASS_A,
    ALU_PASS_B
  } alu_op_t;

  // Map an opcode to the ALU operation that produces its writeback value.
  function automatic alu_op_t alu_op_of(input logic [3:0] opc);
    case (opc)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_MOV:  return ALU_PASS_A;
      default: return ALU_PASS_B;
    endcase
  endfunction

  // ADD..MOV are the only opcodes that write the register file.
  function automatic logic writes_rd(input logic [3:0] opc);
    return (opc >= OP_ADD) && (opc <= OP_MOV);
  endfunction

  function automatic logic is_undefined(input logic [3:0] opc);
    return (opc >= 4'hA) && (opc <= 4'hE);
  endfunction

endpackage

// File: rtl/alu8.sv
// 8-bit combinational ALU; arithmetic wraps modulo 256, no carry out.
module alu8
  import cpu_pkg::*;
(
  input  alu_op_t    op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  // Select the operation result.
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_AND:    y = a & b;
      ALU_OR:     y = a | b;
      ALU_XOR:    y = a ^ b;
      ALU_PASS_A: y = a;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control/execute stage: FETCH -> DECODE -> EXECUTE -> WRITEBACK,
// drives the register file ports and owns the program counter.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [15:0]     instr,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      read_reg1,
  output logic [2:0]      read_reg2,
  input  logic [7:0]      read_data1,
  input  logic [7:0]      read_data2,
  output logic            write_enable,
  output logic [2:0]      write_reg,
  output logic [7:0]      write_data,
  output logic            halted,
  output logic            illegal
);

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [15:0]     ir_q;
  logic [7:0]      opa_q;
  logic [7:0]      opb_q;
  logic            take_q;
  logic            we_q;
  logic [2:0]      wreg_q;
  logic [7:0]      wdata_q;
  logic            halted_q;
  logic            illegal_q;

  logic [3:0]      opcode;
  logic [2:0]      rd;
  logic [7:0]      imm8;
  logic [7:0]      alu_b;
  logic [7:0]      alu_y;
  alu_op_t         alu_op;

  assign opcode = ir_q[OPC_MSB:OPC_LSB];
  assign rd     = ir_q[RD_MSB:RD_LSB];
  assign imm8   = ir_q[IMM_MSB:IMM_LSB];
  assign alu_op = alu_op_of(opcode);
  assign alu_b  = (opcode == OP_LDI) ? imm8 : opb_q;

  alu8 u_alu (
    .op (alu_op),
    .a  (opa_q),
    .b  (alu_b),
    .y  (alu_y)
  );

  // Next pc: jump/branch target (zero-extended imm8) or sequential increment.
  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (take_q) pc_d = PC_W'(imm8);
  end

  // Control FSM with registered writeback, status and pc state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      take_q    <= 1'b0;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          if (instr_valid) begin
            ir_q    <= instr;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          opa_q   <= read_data1;
          opb_q   <= read_data2;
          state_q <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          if (opcode == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
          end else begin
            // Strobe is set here so it is high for exactly the WRITEBACK cycle.
            if (writes_rd(opcode)) begin
              we_q    <= 1'b1;
              wreg_q  <= rd;
              wdata_q <= alu_y;
            end
            take_q  <= (opcode == OP_JMP) || ((opcode == OP_BZ) && (opa_q == '0));
            if (is_undefined(opcode)) illegal_q <= 1'b1;
            state_q <= ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: begin
          pc_q    <= pc_d;
          state_q <= ST_FETCH;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign instr_ready  = (state_q == ST_FETCH);
  assign pc           = pc_q;
  assign read_reg1    = ir_q[RS1_MSB:RS1_LSB];
  assign read_reg2    = ir_q[RS2_MSB:RS2_LSB];
  assign write_enable = we_q;
  assign write_reg    = wreg_q;
  assign write_data   = wdata_q;
  assign halted       = halted_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a behavioural 8x8 register file.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  pc;
  logic [2:0]  read_reg1;
  logic [2:0]  read_reg2;
  logic [7:0]  read_data1;
  logic [7:0]  read_data2;
  logic        write_enable;
  logic [2:0]  write_reg;
  logic [7:0]  write_data;
  logic        halted;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  logic [7:0] rf [8];

  control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .pc           (pc),
    .read_reg1    (read_reg1),
    .read_reg2    (read_reg2),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .halted       (halted),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign read_data1 = rf[read_reg1];
  assign read_data2 = rf[read_reg2];

  always @(posedge clk) begin
    if (write_enable) rf[write_reg] <= write_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"},     32'(write_enable), 32'd0);
    chk({tag, "_wreg"},   32'(write_reg),    32'd0);
    chk({tag, "_wdata"},  32'(write_data),   32'd0);
    chk({tag, "_pc"},     32'(pc),           32'd0);
    chk({tag, "_halted"}, 32'(halted),       32'd0);
    chk({tag, "_illegal"},32'(illegal),      32'd0);
    chk({tag, "_ready"},  32'(instr_ready),  32'd1);
  endtask

  // Issue one instruction after `gap` idle FETCH cycles; called at posedge+1.
  task automatic exec(input string name, input logic [15:0] ins, input int gap,
                      input logic exp_w, input logic [2:0] exp_wr,
                      input logic [7:0] exp_wd, input logic [7:0] exp_pc);
    logic [3:0] we_seq;
    logic [7:0] pc0;
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_ready) chk({name, "_ready_timeout"}, 32'(instr_ready), 32'd1);
    pc0 = pc;
    instr_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      chk({name, "_gap_ready"}, 32'(instr_ready), 32'd1);
      chk({name, "_gap_pc"},    32'(pc),          32'(pc0));
    end
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 16'hFFFF;
    we_seq[3] = write_enable;
    @(posedge clk); #1;
    we_seq[2] = write_enable;
    @(posedge clk); #1;
    we_seq[1] = write_enable;
    chk({name, "_pc_stable"}, 32'(pc), 32'(pc0));
    if (exp_w) begin
      chk({name, "_wreg"},  32'(write_reg),  32'(exp_wr));
      chk({name, "_wdata"}, 32'(write_data), 32'(exp_wd));
    end
    @(posedge clk); #1;
    we_seq[0] = write_enable;
    chk({name, "_we_seq"}, 32'(we_seq), exp_w ? 32'h2 : 32'h0);
    chk({name, "_pc"},     32'(pc),          32'(exp_pc));
    chk({name, "_ready"},  32'(instr_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 16'h0000;
    #1;
    chk_reset("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset("after_release");

    exec("ldi_r1_05", 16'h6205, 0, 1'b1, 3'd1, 8'h05, 8'h01);
    exec("ldi_r1_f0", 16'h62F0, 0, 1'b1, 3'd1, 8'hF0, 8'h02);
    exec("ldi_r2_20", 16'h6420, 0, 1'b1, 3'd2, 8'h20, 8'h03);
    exec("illegal_c", 16'hC000, 1, 1'b0, 3'd0, 8'h00, 8'h04);
    chk("illegal_set", 32'(illegal), 32'd1);
    exec("add_r3",    16'h1650, 2, 1'b1, 3'd3, 8'h10, 8'h05);
    chk("rf_r3", 32'(rf[3]), 32'h10);
    exec("sub_r5",    16'h2A48, 0, 1'b1, 3'd5, 8'h00, 8'h06);
    exec("bz_taken",  16'h9140, 0, 1'b0, 3'd0, 8'h00, 8'h40);
    exec("bz_not",    16'h9040, 0, 1'b0, 3'd0, 8'h00, 8'h41);
    exec("jmp_10",    16'h8010, 0, 1'b0, 3'd0, 8'h00, 8'h10);
    exec("xor_r6",    16'h5C50, 0, 1'b1, 3'd6, 8'hD0, 8'h11);
    exec("and_r7",    16'h3E50, 0, 1'b1, 3'd7, 8'h20, 8'h12);
    exec("or_r6",     16'h4C98, 0, 1'b1, 3'd6, 8'h30, 8'h13);
    exec("mov_r0",    16'h7080, 0, 1'b1, 3'd0, 8'h20, 8'h14);
    exec("sub_wrap",  16'h2888, 0, 1'b1, 3'd4, 8'h30, 8'h15);
    exec("nop",       16'h0000, 3, 1'b0, 3'd0, 8'h00, 8'h16);
    chk("illegal_sticky", 32'(illegal), 32'd1);

    // HALT with instr_valid held high throughout.
    instr = 16'hF000;
    instr_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("halt_halted", 32'(halted),       32'd1);
    chk("halt_ready",  32'(instr_ready),  32'd0);
    chk("halt_we",     32'(write_enable), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("halt_hold_ready", 32'(instr_ready), 32'd0);
      chk("halt_hold_pc",    32'(pc),          32'h16);
      chk("halt_hold_flag",  32'(halted),      32'd1);
    end
    chk("halt_write_reg_pre", 32'(write_reg), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("halt_async_rst");
    instr_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted during WRITEBACK of ADD r7,r1,r2 (r7 holds 0x20).
    instr = 16'h1E50;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wb_rst_we_before", 32'(write_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("wb_rst_we_async", 32'(write_enable), 32'd0);
    chk_reset("wb_rst");
    @(posedge clk); #1;
    chk("wb_rst_r7_kept", 32'(rf[7]), 32'h20);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    exec("post_ldi_r1", 16'h6233, 3, 1'b1, 3'd1, 8'h33, 8'h01);
    exec("post_ldi_r2", 16'h6444, 1, 1'b1, 3'd2, 8'h44, 8'h02);
    exec("post_add_r3", 16'h1650, 2, 1'b1, 3'd3, 8'h77, 8'h03);
    exec("post_mov_r0", 16'h70C0, 0, 1'b1, 3'd0, 8'h77, 8'h04);
    chk("post_illegal", 32'(illegal), 32'd0);
    chk("post_rf_r0",   32'(rf[0]),   32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
